// File: rtl/display_pkg.sv
// Shared types and constants for the 4-digit scan display controller.
// With LEADING_ZERO_BLANK_EN defined it also provides the leading-zero mask helper.
package display_pkg;

  localparam int N_DIGITS = 4;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hB;

  // Segment vector ordered {G,F,E,D,C,B,A}.
  typedef logic [6:0] seg_t;

  typedef enum logic {BLANK, ON} scan_state_t;

`ifdef LEADING_ZERO_BLANK_EN
  // Walk from the leftmost digit down to digit 1. A zero code without a decimal
  // point is suppressed. A blank code passes through unchanged. Anything else
  // ends the leading run. Digit 0 is never suppressed.
  function automatic logic [N_DIGITS-1:0] leadingZeroMask(
    input logic [4*N_DIGITS-1:0] value,
    input logic [N_DIGITS-1:0]   dpMask
  );
    logic [N_DIGITS-1:0] mask;
    logic                stillLeading;
    logic [3:0]          code;
    mask         = '0;
    stillLeading = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      code = value[4*i +: 4];
      if (stillLeading && !dpMask[i]) begin
        if (code == 4'h0) begin
          mask[i] = 1'b1;
        end else if (code < CODE_BLANK) begin
          stillLeading = 1'b0;
        end
      end else begin
        stillLeading = 1'b0;
      end
    end
    return mask;
  endfunction
`endif

endpackage

// File: rtl/display_scan_ctrl_if.sv
// Core-to-display bundle. The master side is the core, and the slave side is the scan controller.
interface display_scan_ctrl_if;
  import display_pkg::*;

  logic [4*N_DIGITS-1:0] Value;
  logic [N_DIGITS-1:0]   DpMask;
  logic                  Load;
  logic                  Pending;
  logic                  SegA, SegB, SegC, SegD, SegE, SegF, SegG;
  logic                  DP;
  logic [N_DIGITS-1:0]   nDigit;

  modport master (
    output Value, DpMask, Load,
    input  Pending, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, nDigit
  );

  modport slave (
    input  Value, DpMask, Load,
    output Pending, SegA, SegB, SegC, SegD, SegE, SegF, SegG, DP, nDigit
  );
endinterface

// File: rtl/seg7_decode.sv
// Nibble to 7-segment glyph: 0-9 are decimal digits, A is a dash, and B-F are blank.
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code,
  output seg_t       seg
);

  // Glyph lookup.
  always_comb begin
    // NOTE: default assigned first so no path leaves seg unassigned (no latch).
    seg = '0;
    case (code)
      4'h0:      seg = 7'h3F;
      4'h1:      seg = 7'h06;
      4'h2:      seg = 7'h5B;
      4'h3:      seg = 7'h4F;
      4'h4:      seg = 7'h66;
      4'h5:      seg = 7'h6D;
      4'h6:      seg = 7'h7D;
      4'h7:      seg = 7'h07;
      4'h8:      seg = 7'h7F;
      4'h9:      seg = 7'h6F;
      CODE_DASH: seg = 7'h40;
      default:   seg = '0;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for the 4-digit 7-segment display.
// The controller double-buffers the display word, adds blank gaps between digit slots,
// and swaps in new data only at frame boundaries.
// Optional: LEADING_ZERO_BLANK_EN suppresses leading zeros, using a mask taken at transfer.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int SCAN_DIV     = 32,
  parameter int BLANK_CYCLES = 2
) (
  input logic                Clock,
  input logic                nReset,
  display_scan_ctrl_if.slave bus
);

  localparam int                CNT_W      = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0]  SLOT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam int                DIG_W      = $clog2(N_DIGITS);
  localparam logic [DIG_W-1:0]  DIGIT_LAST = DIG_W'(N_DIGITS - 1);
  localparam int                VAL_W      = 4 * N_DIGITS;

  scan_state_t         state, stateNext;
  logic [CNT_W-1:0]    slotCnt, slotCntNext;
  logic [DIG_W-1:0]    digit, digitNext;
  logic                slotEnd, frameEnd;

  logic [VAL_W-1:0]    pendValue, activeValue, xferValue;
  logic [N_DIGITS-1:0] pendDp, activeDp, xferDp;
  logic                pendingQ, doXfer;

  logic [3:0]          digitCode;
  seg_t                digitSeg;
  logic                digitDp, digitLit;

  seg_t                segQ;
  logic                dpQ;
  logic [N_DIGITS-1:0] nDigitQ;

  assign slotEnd  = (slotCnt == SLOT_LAST);
  assign frameEnd = slotEnd && (digit == DIGIT_LAST);

  // Scan position: the state, the slot counter and the digit index.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= BLANK;
      slotCnt <= '0;
      digit   <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values together.
      state   <= stateNext;
      slotCnt <= slotCntNext;
      digit   <= digitNext;
    end
  end

  // Slot counter wrap, digit advance and BLANK/ON sequencing.
  always_comb begin
    stateNext   = state;
    slotCntNext = slotEnd ? '0 : slotCnt + 1'b1;
    digitNext   = slotEnd ? digit + 1'b1 : digit;
    case (state)
      BLANK:   if (BLANK_CYCLES == 0 || slotCnt == BLANK_LAST) stateNext = ON;
      ON:      if (slotEnd && BLANK_CYCLES != 0) stateNext = BLANK;
      default: stateNext = BLANK;
    endcase
  end

  // A Load on the boundary cycle bypasses the pending buffer and wins.
  assign doXfer    = frameEnd && (bus.Load || pendingQ);
  assign xferValue = bus.Load ? bus.Value  : pendValue;
  assign xferDp    = bus.Load ? bus.DpMask : pendDp;

  // Pending/active double buffer and the Pending flag.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      pendValue   <= '0;
      pendDp      <= '0;
      // NOTE: buffers are plain flops, so they reset to a dark display, not to X.
      activeValue <= {N_DIGITS{CODE_BLANK}};
      activeDp    <= '0;
      pendingQ    <= 1'b0;
    end else begin
      if (bus.Load) begin
        pendValue <= bus.Value;
        pendDp    <= bus.DpMask;
      end
      if (doXfer) begin
        activeValue <= xferValue;
        activeDp    <= xferDp;
      end
      pendingQ <= !frameEnd && (bus.Load || pendingQ);
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] suppressMask;

  // Leading-zero mask, captured together with the data it describes.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      suppressMask <= '0;
    end else if (doXfer) begin
      suppressMask <= leadingZeroMask(xferValue, xferDp);
    end
  end

  assign digitCode = suppressMask[digit] ? CODE_BLANK : activeValue[{digit, 2'b00} +: 4];
`else
  assign digitCode = activeValue[{digit, 2'b00} +: 4];
`endif

  assign digitDp  = activeDp[digit];
  assign digitLit = (digitSeg != '0) || digitDp;

  seg7_decode uDecode (
    .code (digitCode),
    .seg  (digitSeg)
  );

  // Registered pad drives. A digit with nothing to light keeps its enable off.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      segQ    <= '0;
      dpQ     <= 1'b0;
      nDigitQ <= '1;
    end else if (state == ON && digitLit) begin
      segQ    <= digitSeg;
      dpQ     <= digitDp;
      nDigitQ <= ~(N_DIGITS'(1) << digit);
    end else begin
      segQ    <= '0;
      dpQ     <= 1'b0;
      nDigitQ <= '1;
    end
  end

  assign bus.Pending = pendingQ;
  assign bus.SegA    = segQ[0];
  assign bus.SegB    = segQ[1];
  assign bus.SegC    = segQ[2];
  assign bus.SegD    = segQ[3];
  assign bus.SegE    = segQ[4];
  assign bus.SegF    = segQ[5];
  assign bus.SegG    = segQ[6];
  assign bus.DP      = dpQ;
  assign bus.nDigit  = nDigitQ;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (default SCAN_DIV=32, BLANK_CYCLES=2).
// Output word = {nDigit[3:0], DP, G,F,E,D,C,B,A}.
module tb_display_scan_ctrl;
  import display_pkg::*;

  localparam int SCAN_DIV     = 32;
  localparam int BLANK_CYCLES = 2;
  localparam int FRAME        = 4 * SCAN_DIV;
  localparam int N_VEC        = 7;

  logic Clock;
  logic nReset;

  display_scan_ctrl_if dsIf ();

  display_scan_ctrl #(
    .SCAN_DIV     (SCAN_DIV),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) dut (
    .Clock  (Clock),
    .nReset (nReset),
    .bus    (dsIf)
  );

  typedef struct {
    logic [15:0]     value;
    logic [3:0]      dpMask;
    logic [3:0][6:0] seg;     // expected glyph per digit, {d3,d2,d1,d0}
  } vec_t;

  vec_t vecs [N_VEC];
  vec_t sb   [$];

  int nCompared   = 0;
  int nMismatched = 0;
  int cyc;

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Cycle index since reset release, i.e. the DUT's internal cycle number.
  always @(posedge Clock or negedge nReset) begin
    if (!nReset) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] outWord();
    return {dsIf.nDigit, dsIf.DP, dsIf.SegG, dsIf.SegF, dsIf.SegE,
            dsIf.SegD, dsIf.SegC, dsIf.SegB, dsIf.SegA};
  endfunction

  function automatic bit litOf(input vec_t e, input int i);
    return (e.seg[i] != 7'h0) || e.dpMask[i];
  endfunction

  function automatic logic [11:0] expWord(input vec_t e, input int i);
    logic [3:0] nd;
    nd = litOf(e, i) ? ~(4'b0001 << i) : 4'hF;
    return {nd, e.dpMask[i], e.seg[i]};
  endfunction

  // Advance to the falling edge inside DUT cycle c.
  task automatic at_cycle(input int c);
    while (cyc != c) begin
      if (cyc > c) begin
        nCompared++;
        nMismatched++;
        $display("FAIL at_cycle: now %0d, wanted %0d", cyc, c);
        return;
      end
      @(negedge Clock);
    end
  endtask

  task automatic load(input logic [15:0] value, input logic [3:0] dp);
    dsIf.Value  = value;
    dsIf.DpMask = dp;
    dsIf.Load   = 1'b1;
  endtask

  // Load mid-frame f, then check every output cycle of frame f+1.
  task automatic run_vector(input int v, input int f);
    int         base;
    vec_t       e;
    logic [11:0] w;
    logic [3:0] nd;
    int         lowCnt [4];
    int         multi;
    logic [3:0] ndHist [FRAME+1];
    base = f * FRAME;
    at_cycle(base + FRAME / 2);
    load(vecs[v].value, vecs[v].dpMask);
    sb.push_back(vecs[v]);
    at_cycle(base + FRAME / 2 + 1);
    dsIf.Load = 1'b0;
    check($sformatf("v%0d_pending_after_load", v), 32'(dsIf.Pending), 32'(1));
    at_cycle(base + FRAME - 1);
    check($sformatf("v%0d_pending_at_boundary", v), 32'(dsIf.Pending), 32'(1));
    at_cycle(base + FRAME);
    check($sformatf("v%0d_pending_after_xfer", v), 32'(dsIf.Pending), 32'(0));
    if (sb.size() == 0) begin
      nCompared++;
      nMismatched++;
      $display("FAIL v%0d_scoreboard: queue empty", v);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < 4; i++) lowCnt[i] = 0;
    multi = 0;
    for (int k = 1; k <= FRAME; k++) begin
      at_cycle(base + FRAME + k);
      w         = outWord();
      nd        = w[11:8];
      ndHist[k] = nd;
      if ($countones(~nd) > 1) multi++;
      for (int i = 0; i < 4; i++) begin
        if (nd == ~(4'b0001 << i)) lowCnt[i]++;
        if (k == SCAN_DIV * i + SCAN_DIV / 2)
          check($sformatf("v%0d_digit%0d", v, i), 32'(w), 32'(expWord(e, i)));
      end
    end
    for (int i = 0; i < 4; i++)
      check($sformatf("v%0d_digit%0d_on_cycles", v, i), 32'(lowCnt[i]),
            32'(litOf(e, i) ? SCAN_DIV - BLANK_CYCLES : 0));
    check($sformatf("v%0d_multi_low", v), 32'(multi), 32'(0));
    if (v == 0) begin
      check("gap_first_blank", 32'(ndHist[2]),  32'(4'b1111));
      check("gap_first_on",    32'(ndHist[3]),  32'(4'b1110));
      check("gap_d0_last_on",  32'(ndHist[32]), 32'(4'b1110));
      check("gap_blank_a",     32'(ndHist[33]), 32'(4'b1111));
      check("gap_blank_b",     32'(ndHist[34]), 32'(4'b1111));
      check("gap_d1_first_on", 32'(ndHist[35]), 32'(4'b1101));
    end
  endtask

  initial begin
    logic [11:0] w;
    logic [11:0] hist [9];
    int bad, ones, twos, base;

    vecs[0] = '{value: 16'h1234, dpMask: 4'b0100, seg: {7'h06, 7'h5B, 7'h4F, 7'h66}};
    vecs[1] = '{value: 16'h5678, dpMask: 4'b0000, seg: {7'h6D, 7'h7D, 7'h07, 7'h7F}};
    vecs[2] = '{value: 16'h90AB, dpMask: 4'b0011, seg: {7'h6F, 7'h3F, 7'h40, 7'h00}};
    vecs[3] = '{value: 16'hCDEF, dpMask: 4'b0000, seg: {7'h00, 7'h00, 7'h00, 7'h00}};
    vecs[4] = '{value: 16'h0000, dpMask: 4'b1111, seg: {7'h3F, 7'h3F, 7'h3F, 7'h3F}};
`ifdef LEADING_ZERO_BLANK_EN
    vecs[5] = '{value: 16'h0050, dpMask: 4'b0000, seg: {7'h00, 7'h00, 7'h6D, 7'h3F}};
`else
    vecs[5] = '{value: 16'h0050, dpMask: 4'b0000, seg: {7'h3F, 7'h3F, 7'h6D, 7'h3F}};
`endif
    vecs[6] = '{value: 16'h0050, dpMask: 4'b1000, seg: {7'h3F, 7'h3F, 7'h6D, 7'h3F}};

    dsIf.Value  = '0;
    dsIf.DpMask = '0;
    dsIf.Load   = 1'b0;
    nReset      = 1'b1;
    #2 nReset   = 1'b0;
    #1;
    check("reset_out",     32'(outWord()),     32'(12'hF00));
    check("reset_pending", 32'(dsIf.Pending),  32'(0));
    repeat (3) @(negedge Clock);
    nReset = 1'b1;

    // Idle after reset: all-blank buffer, so the display stays dark.
    bad = 0;
    for (int c = 0; c < 4 * FRAME; c++) begin
      at_cycle(c);
      if (outWord() !== 12'hF00 || dsIf.Pending !== 1'b0) bad++;
    end
    check("idle_dark_cycles", 32'(bad), 32'(0));

    for (int v = 0; v < N_VEC; v++) run_vector(v, 4 + 2 * v);

    // Load on the boundary cycle: no Pending, and digit 0 appears 4 cycles later.
    base = 18 * FRAME;
    at_cycle(base + FRAME - 1);
    load(16'h8888, 4'b0000);
    for (int k = 0; k < 9; k++) begin
      at_cycle(base + FRAME + k);
      dsIf.Load = 1'b0;
      hist[k] = outWord();
      if (dsIf.Pending !== 1'b0) bad++;
    end
    check("bnd_pending_never", 32'(bad), 32'(0));
    check("bnd_prev_digit3",   32'(hist[0]), 32'(12'h7BF));
    check("bnd_still_blank",   32'(hist[2]), 32'(12'hF00));
    check("bnd_new_digit0",    32'(hist[3]), 32'(12'hE7F));

    // Two Loads within one frame: the second one wins.
    base = 19 * FRAME;
    at_cycle(base + 40);
    load(16'h1111, 4'b0000);
    at_cycle(base + 41);
    dsIf.Load = 1'b0;
    at_cycle(base + 80);
    load(16'h2222, 4'b0000);
    at_cycle(base + 81);
    dsIf.Load = 1'b0;
    check("dbl_pending", 32'(dsIf.Pending), 32'(1));
    ones = 0;
    twos = 0;
    for (int c = base + 82; c <= base + 3 * FRAME; c++) begin
      at_cycle(c);
      w = outWord();
      if (w[6:0] == 7'h06) ones++;
      if (c > base + FRAME && w[7:0] == 8'h5B && $countones(~w[11:8]) == 1) twos++;
    end
    check("dbl_first_never_shown", 32'(ones), 32'(0));
    check("dbl_second_on_cycles",  32'(twos), 32'(8 * (SCAN_DIV - BLANK_CYCLES)));

    // Asynchronous reset in the digit-2 ON slot, with a Load still pending.
    base = 22 * FRAME;
    at_cycle(base + 70);
    load(16'h7777, 4'b0000);
    at_cycle(base + 71);
    dsIf.Load = 1'b0;
    check("rst_pre_pending", 32'(dsIf.Pending), 32'(1));
    at_cycle(base + 74);
    check("rst_pre_digit2", 32'(outWord()), 32'(12'hB5B));
    #1 nReset = 1'b0;
    #1;
    check("rst_async_out",     32'(outWord()),    32'(12'hF00));
    check("rst_async_pending", 32'(dsIf.Pending), 32'(0));
    repeat (2) @(negedge Clock);
    nReset = 1'b1;
    bad = 0;
    for (int c = 0; c < 2 * FRAME - 1; c++) begin
      at_cycle(c);
      if (outWord() !== 12'hF00 || dsIf.Pending !== 1'b0) bad++;
    end
    check("rst_dark_after_release", 32'(bad), 32'(0));
    load(16'h0123, 4'b0000);
    at_cycle(2 * FRAME);
    dsIf.Load = 1'b0;
    check("rst_bnd_pending", 32'(dsIf.Pending), 32'(0));
    at_cycle(2 * FRAME + 2);
    check("rst_digit0_blank_gap", 32'(outWord()), 32'(12'hF00));
    at_cycle(2 * FRAME + 3);
    check("rst_digit0_on", 32'(outWord()), 32'(12'hE4F));
    at_cycle(2 * FRAME + SCAN_DIV + 3);
    check("rst_digit1_on", 32'(outWord()), 32'(12'hD5B));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
